// File: rtl/mul_result_accumulator.sv
// Sums a frame of signed/unsigned multiplier products into a widened accumulator with a sticky overflow flag.
// Result valid one cycle after the last beat; up_ready stays low while a result waits for down_ready.
module mul_result_accumulator #(
    parameter int n = 8,
    parameter int g = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [2*n-1:0]    up_res,
    input  logic              up_signed,
    input  logic              up_last,
    output logic              down_valid,
    input  logic              down_ready,
    output logic [2*n+g-1:0]  down_sum,
    output logic              down_overflow
);
    localparam int aw = 2*n + g;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t          state;
    logic [aw-1:0]   acc;
    logic            mode;
    logic            ovf;

    logic            eff_mode;
    logic [aw-1:0]   ext;
    logic [aw-1:0]   acc_base;
    logic [aw:0]     sum_w;
    logic [aw-1:0]   nxt;
    logic            add_ovf;
    logic            ovf_next;
    logic            beat_acc;

    assign up_ready = (state != HOLD);
    assign beat_acc = up_valid && up_ready;

    // The first beat of a frame decides the mode before it has been latched.
    assign eff_mode = (state == IDLE) ? up_signed : mode;
    assign ext      = eff_mode ? {{g{up_res[2*n-1]}}, up_res} : {{g{1'b0}}, up_res};
    assign acc_base = (state == IDLE) ? '0 : acc;
    assign sum_w    = {1'b0, acc_base} + {1'b0, ext};
    assign nxt      = sum_w[aw-1:0];

    always_comb begin
        add_ovf = 1'b0;
        if (eff_mode)
            add_ovf = (acc_base[aw-1] == ext[aw-1]) && (nxt[aw-1] != acc_base[aw-1]);
        else
            add_ovf = sum_w[aw];
    end

    assign ovf_next = ((state == IDLE) ? 1'b0 : ovf) | add_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            mode          <= 1'b0;
            ovf           <= 1'b0;
            down_valid    <= 1'b0;
            down_sum      <= '0;
            down_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (beat_acc) begin
                        if (state == IDLE)
                            mode <= up_signed;
                        if (up_last) begin
                            down_sum      <= nxt;
                            down_overflow <= ovf_next;
                            down_valid    <= 1'b1;
                            acc           <= '0;
                            ovf           <= 1'b0;
                            state         <= HOLD;
                        end else begin
                            acc   <= nxt;
                            ovf   <= ovf_next;
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (down_valid && down_ready) begin
                        down_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_result_accumulator.sv
module tb_mul_result_accumulator;
    localparam int N  = 4;
    localparam int G  = 4;
    localparam int AW = 2*N + G;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            up_valid;
    logic            up_ready;
    logic [2*N-1:0]  up_res;
    logic            up_signed;
    logic            up_last;
    logic            down_valid;
    logic            down_ready;
    logic [AW-1:0]   down_sum;
    logic            down_overflow;

    int checks   = 0;
    int failures = 0;

    mul_result_accumulator #(.n(N), .g(G)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .up_valid      (up_valid),
        .up_ready      (up_ready),
        .up_res        (up_res),
        .up_signed     (up_signed),
        .up_last       (up_last),
        .down_valid    (down_valid),
        .down_ready    (down_ready),
        .down_sum      (down_sum),
        .down_overflow (down_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          len;
        logic [63:0] vals;
        logic [7:0]  sgn;
        logic [11:0] exp_sum;
        logic        exp_ovf;
    } frame_t;

    frame_t vec[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered and left at a falling edge; the beat is accepted at the rising edge in between.
    task automatic send_beat(input logic [7:0] v, input logic s, input logic l);
        int t = 0;
        up_valid  = 1'b1;
        up_res    = v;
        up_signed = s;
        up_last   = l;
        while (!up_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("up_ready_timeout", {31'b0, up_ready}, 32'd1);
        @(negedge clk);
        up_valid = 1'b0;
        up_last  = 1'b0;
    endtask

    task automatic take_result(input string nm, input logic [11:0] es, input logic eo, input int hold);
        check({nm, "_valid"}, {31'b0, down_valid}, 32'd1);
        check({nm, "_sum"}, {20'b0, down_sum}, {20'b0, es});
        check({nm, "_ovf"}, {31'b0, down_overflow}, {31'b0, eo});
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({nm, "_held_valid"}, {31'b0, down_valid}, 32'd1);
            check({nm, "_held_sum"}, {20'b0, down_sum}, {20'b0, es});
        end
        down_ready = 1'b1;
        @(negedge clk);
        down_ready = 1'b0;
        check({nm, "_released"}, {31'b0, down_valid}, 32'd0);
        check({nm, "_ready_back"}, {31'b0, up_ready}, 32'd1);
    endtask

    function automatic frame_t mk(input string nm, input int len, input logic [63:0] vals,
                                  input logic [7:0] sgn, input logic [11:0] es, input logic eo);
        frame_t f;
        f.name = nm; f.len = len; f.vals = vals; f.sgn = sgn; f.exp_sum = es; f.exp_ovf = eo;
        return f;
    endfunction

    // Reference: true integer running sum, wrapped into the accumulator range after each add.
    task automatic model(input int q[$], input bit mode, output logic [11:0] es, output bit eo);
        int acc = 0;
        int v;
        int t;
        eo = 1'b0;
        foreach (q[i]) begin
            v = q[i];
            if (mode && v >= 128) v = v - 256;
            t = acc + v;
            if (mode) begin
                if (t > 2047 || t < -2048) eo = 1'b1;
                t = t & 4095;
                if (t >= 2048) t = t - 4096;
            end else begin
                if (t > 4095) eo = 1'b1;
                t = t & 4095;
            end
            acc = t;
        end
        es = acc[11:0];
    endtask

    initial begin
        logic [11:0] es;
        bit          eo;
        int          q[$];
        bit          mode;
        int          len;

        rst_n = 1'b0; up_valid = 1'b0; up_res = '0; up_signed = 1'b0; up_last = 1'b0; down_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_down_valid", {31'b0, down_valid}, 32'd0);
        check("rst_down_sum", {20'b0, down_sum}, 32'd0);
        check("rst_down_ovf", {31'b0, down_overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_up_ready", {31'b0, up_ready}, 32'd1);

        vec.push_back(mk("u_e1_e1",      2, 64'hE1E1,   8'b00,  12'h1C2, 1'b0));
        vec.push_back(mk("s_40_c8",      2, 64'hC840,   8'b11,  12'h008, 1'b0));
        vec.push_back(mk("s_40_c8_tog",  2, 64'hC840,   8'b01,  12'h008, 1'b0));
        vec.push_back(mk("s_single_c8",  1, 64'hC8,     8'b1,   12'hFC8, 1'b0));
        vec.push_back(mk("u_ff_ff",      2, 64'hFFFF,   8'b00,  12'h1FE, 1'b0));
        vec.push_back(mk("s_80_80",      2, 64'h8080,   8'b11,  12'hF00, 1'b0));
        vec.push_back(mk("s_ff_x3",      3, 64'hFFFFFF, 8'b111, 12'hFFD, 1'b0));
        vec.push_back(mk("u_single_01",  1, 64'h01,     8'b0,   12'h001, 1'b0));

        foreach (vec[k]) begin
            for (int i = 0; i < vec[k].len; i++)
                send_beat(vec[k].vals[8*i +: 8], vec[k].sgn[i], i == vec[k].len - 1);
            take_result(vec[k].name, vec[k].exp_sum, vec[k].exp_ovf, 0);
        end

        for (int i = 0; i < 19; i++) send_beat(8'hE1, 1'b0, i == 18);
        take_result("u_ovf_19xe1", 12'h0B3, 1'b1, 0);
        for (int i = 0; i < 33; i++) send_beat(8'h40, 1'b1, i == 32);
        take_result("s_ovf_33x40", 12'h840, 1'b1, 0);
        send_beat(8'h01, 1'b0, 1'b1);
        take_result("ovf_cleared", 12'h001, 1'b0, 0);

        // Backpressure with a beat waiting upstream.
        send_beat(8'h10, 1'b0, 1'b0);
        send_beat(8'h20, 1'b0, 1'b1);
        check("bp_valid", {31'b0, down_valid}, 32'd1);
        up_valid = 1'b1; up_res = 8'h07; up_signed = 1'b0; up_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'b0, down_valid}, 32'd1);
            check("bp_hold_sum", {20'b0, down_sum}, 32'h030);
            check("bp_hold_ovf", {31'b0, down_overflow}, 32'd0);
            check("bp_hold_up_ready", {31'b0, up_ready}, 32'd0);
        end
        down_ready = 1'b1;
        @(negedge clk);
        down_ready = 1'b0;
        check("bp_release_valid", {31'b0, down_valid}, 32'd0);
        check("bp_release_up_ready", {31'b0, up_ready}, 32'd1);
        @(negedge clk);
        up_valid = 1'b0; up_last = 1'b0;
        take_result("bp_pending_beat", 12'h007, 1'b0, 0);

        // Reset mid-frame discards the partial sum.
        send_beat(8'hE1, 1'b0, 1'b0);
        send_beat(8'hE1, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_valid", {31'b0, down_valid}, 32'd0);
        send_beat(8'h05, 1'b0, 1'b1);
        take_result("rst_mid_frame", 12'h005, 1'b0, 0);

        send_beat(8'h03, 1'b0, 1'b1);
        check("rst_hold_pre_valid", {31'b0, down_valid}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_hold_valid", {31'b0, down_valid}, 32'd0);
        check("rst_hold_sum", {20'b0, down_sum}, 32'd0);
        check("rst_hold_up_ready", {31'b0, up_ready}, 32'd1);

        // Randomised frames against the integer reference.
        for (int f = 0; f < 60; f++) begin
            q.delete();
            len  = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
            mode = $urandom_range(0, 1);
            for (int i = 0; i < len; i++) begin
                q.push_back($urandom_range(0, 255));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_beat(q[i][7:0], (i == 0) ? mode : 1'($urandom_range(0, 1)), i == len - 1);
            end
            model(q, mode, es, eo);
            take_result("rand_frame", es, eo, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
